seq_divider: RTL and testbench

//  Iterative restoring divider for the multicycle MIPS datapath. Implements div/divu.

---
 rtl/seq_divider_pkg.sv | 14 +
 rtl/seq_divider_if.sv | 26 ++
 rtl/seq_divider.sv | 124 ++++++++++++
 tb/tb_seq_divider.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the iterative divider: state encodings and default width.
// The control unit imports this too, so mult/div state decoding stays consistent.
package seq_divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage : seq_divider_pkg

// File: rtl/seq_divider_if.sv
// Request/result bundle between the control unit (master) and the divider (slave).
interface seq_divider_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, div_zero, quotient, remainder
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, div_zero, quotient, remainder
  );

endinterface : seq_divider_if

// File: rtl/seq_divider.sv
// Iterative restoring divider for div/divu: one quotient bit per cycle on magnitudes,
// signs applied in a final fix-up cycle. Quotient feeds LO, remainder feeds HI.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  seq_divider_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             done_q;
  logic             div_zero_q;

  // One extra bit on the trial remainder keeps divu with MSB-set operands from overflowing.
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic             a_neg, b_neg;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    div0_d  = div0_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    trial   = {r_q, q_q[WIDTH-1]};
    diff    = trial - {1'b0, d_q};
    fits    = (trial >= {1'b0, d_q});
    a_neg   = bus.is_signed & bus.dividend[WIDTH-1];
    b_neg   = bus.is_signed & bus.divisor[WIDTH-1];

    unique case (state_q)
      DIV_IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            div0_d  = 1'b1;
            state_d = DIV_DONE;
          end else begin
            // INT_MIN negates to itself, which is its correct magnitude read as unsigned.
            q_d     = a_neg ? -bus.dividend : bus.dividend;
            d_d     = b_neg ? -bus.divisor  : bus.divisor;
            r_d     = '0;
            cnt_d   = CNT_W'(WIDTH - 1);
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
            div0_d  = 1'b0;
            state_d = DIV_RUN;
          end
        end
      end
      DIV_RUN: begin
        r_d   = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], fits};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = DIV_FIX;
      end
      DIV_FIX: begin
        quot_d  = q_neg_q ? -q_q : q_q;
        rem_d   = r_neg_q ? -r_q : r_q;
        state_d = DIV_DONE;
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= DIV_IDLE;
      r_q        <= '0;
      q_q        <= '0;
      d_q        <= '0;
      cnt_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div0_q     <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      q_q        <= q_d;
      d_q        <= d_d;
      cnt_q      <= cnt_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      div0_q     <= div0_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      done_q     <= (state_q == DIV_DONE);
      div_zero_q <= (state_q == DIV_DONE) && div0_q;
    end
  end

  assign bus.busy      = (state_q != DIV_IDLE);
  assign bus.done      = done_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: hand-computed div/divu vectors, latency, busy window,
// divide-by-zero, ignored re-start and asynchronous reset mid-iteration.
module tb_seq_divider;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  seq_divider_if #(.WIDTH(32)) bus ();

  seq_divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one operation and checks latency, busy window, done/div_zero pulses and results.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_q,
                        input logic [31:0] exp_r, input logic exp_dz,
                        input int exp_lat, input int repulse_at);
    int n;
    int busy_cnt;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = 32'hDEAD_BEEF;
    bus.divisor  = 32'h0000_0003;
    bus.is_signed = ~sgn;
    n        = 0;
    busy_cnt = 0;
    while (!bus.done && n < 100) begin
      if (bus.busy) busy_cnt++;
      if (n == repulse_at) begin
        bus.start    = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    bus.start = 1'b0;
    check({tag, " latency"}, n, exp_lat);
    check({tag, " busy_cycles"}, busy_cnt, exp_lat);
    check({tag, " busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    check({tag, " quotient"}, bus.quotient, exp_q);
    check({tag, " remainder"}, bus.remainder, exp_r);
    check({tag, " div_zero"}, {31'd0, bus.div_zero}, {31'd0, exp_dz});
    @(posedge clk);
    #1;
    check({tag, " done_pulse_len"}, {31'd0, bus.done}, 32'd0);
    check({tag, " div_zero_fall"}, {31'd0, bus.div_zero}, 32'd0);
    check({tag, " quotient_hold"}, bus.quotient, exp_q);
  endtask

  initial begin
    int done_seen;
    n_cmp = 0;
    n_bad = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset div_zero", {31'd0, bus.div_zero}, 32'd0);
    check("reset quotient", bus.quotient, 32'd0);
    check("reset remainder", bus.remainder, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_div("s 7/2",        1'b1, 32'd7,        32'd2,        32'd3,        32'd1,        1'b0, 34, -1);
    do_div("s -7/2",       1'b1, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, -1);
    do_div("u ffffffff/16", 1'b0, 32'hFFFF_FFFF, 32'h10,     32'h0FFF_FFFF, 32'hF,        1'b0, 34, -1);
    do_div("s ffffffff/16", 1'b1, 32'hFFFF_FFFF, 32'h10,     32'd0,        32'hFFFF_FFFF, 1'b0, 34, -1);
    do_div("s 7/-2",       1'b1, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,       1'b0, 34, -1);
    do_div("s -7/-2",      1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,       32'hFFFF_FFFF, 1'b0, 34, -1);
    do_div("u 80000000/ffffffff", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 34, -1);
    do_div("u 100/7",      1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 34, -1);
    // Divide by zero keeps the prior 14 r 2.
    do_div("x/0",          1'b1, 32'd9,        32'd0,        32'd14,       32'd2,        1'b1, 1,  -1);
    do_div("s intmin/-1",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,    1'b0, 34, 5);
    do_div("u 1000/3",     1'b0, 32'd1000,     32'd3,        32'd333,      32'd1,        1'b0, 34, -1);

    // Asynchronous reset ten cycles into an iteration.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd5000;
    bus.divisor   = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midreset busy", {31'd0, bus.busy}, 32'd0);
    check("midreset quotient", bus.quotient, 32'd0);
    check("midreset remainder", bus.remainder, 32'd0);
    check("midreset done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) done_seen++;
    end
    check("midreset no_done", done_seen, 0);

    do_div("after reset 5000/7", 1'b0, 32'd5000, 32'd7, 32'd714, 32'd2, 1'b0, 34, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_seq_divider
